// File: rtl/bomb_manager.sv
// Bomb manager: keeps a small pool of bomb slots, runs each slot's fuse and
// blast timers, chains blasts into armed bombs, and decodes the tile maps
// (walkable, bomb, blast) from the slot registers.
module bomb_manager #(
    parameter int HMAXTILE  = 9,
    parameter int VMAXTILE  = 5,
    parameter int NUMSLOT   = 4,
    parameter int FUSE_CYC  = 50_000_000,
    parameter int BLAST_CYC = 25_000_000,
    parameter int RANGE     = 2,
    parameter int CNTW      = 26,
    localparam int NT       = (HMAXTILE + 1) * (VMAXTILE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          place,
    input  logic [3:0]    curh,
    input  logic [3:0]    curv,
    input  logic [NT-1:0] wallMap,
    output logic [NT:0]   walkAble,
    output logic [NT-1:0] bombMap,
    output logic [NT-1:0] blastMap,
    output logic          placeAck,
    output logic [3:0]    activeCnt
);

    localparam int W    = HMAXTILE + 1;
    localparam int IDXW = (NT > 1) ? $clog2(NT) : 1;
    localparam int SLW  = (NUMSLOT > 1) ? $clog2(NUMSLOT) : 1;

    localparam logic [CNTW-1:0] FUSE_LAST  = CNTW'(FUSE_CYC - 1);
    localparam logic [CNTW-1:0] BLAST_LAST = CNTW'(BLAST_CYC - 1);
    localparam logic [3:0]      HMAX4      = 4'(HMAXTILE);
    localparam logic [3:0]      VMAX4      = 4'(VMAXTILE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2
    } slot_state_e;

    // Row-major tile numbering shared by every map.
    function automatic logic [IDXW-1:0] tile_idx(input int h, input int v);
        return IDXW'(v * W + h);
    endfunction

    // Blast shape of one bomb: centre plus four arms, each arm cut at the grid
    // edge and stopping just before the first wall it meets.
    function automatic logic [NT-1:0] footprint(input logic [3:0] ch,
                                                input logic [3:0] cv,
                                                input logic [NT-1:0] walls);
        logic [NT-1:0]   fp;
        logic            arm_open;
        int              nh;
        int              nv;
        logic [IDXW-1:0] idx;
        fp = '0;
        fp[tile_idx(int'(ch), int'(cv))] = 1'b1;
        for (int dir = 0; dir < 4; dir++) begin
            arm_open = 1'b1;
            for (int d = 1; d <= RANGE; d++) begin
                nh = int'(ch);
                nv = int'(cv);
                case (dir)
                    0:       nh = nh - d;
                    1:       nh = nh + d;
                    2:       nv = nv - d;
                    default: nv = nv + d;
                endcase
                if (arm_open) begin
                    if (nh < 0 || nh > HMAXTILE || nv < 0 || nv > VMAXTILE) begin
                        arm_open = 1'b0;
                    end else begin
                        idx = tile_idx(nh, nv);
                        if (walls[idx]) begin
                            arm_open = 1'b0;
                        end else begin
                            fp[idx] = 1'b1;
                        end
                    end
                end
            end
        end
        return fp;
    endfunction

    slot_state_e     state_q [NUMSLOT];
    slot_state_e     state_d [NUMSLOT];
    logic [3:0]      h_q     [NUMSLOT];
    logic [3:0]      h_d     [NUMSLOT];
    logic [3:0]      v_q     [NUMSLOT];
    logic [3:0]      v_d     [NUMSLOT];
    logic [CNTW-1:0] timer_q [NUMSLOT];
    logic [CNTW-1:0] timer_d [NUMSLOT];
    logic            place_ack_q;
    logic            place_ack_d;

    logic [NT-1:0]   bomb_map;
    logic [NT-1:0]   blast_map;
    logic            cur_in_range;
    logic [IDXW-1:0] cur_idx;
    logic            free_found;
    logic [SLW-1:0]  free_idx;
    logic            accept;
    logic [3:0]      active_cnt;

    // Decode the bomb and blast maps from the current slot registers.
    always_comb begin
        bomb_map  = '0;
        blast_map = '0;
        for (int s = 0; s < NUMSLOT; s++) begin
            if (state_q[s] == S_ARMED) begin
                bomb_map[tile_idx(int'(h_q[s]), int'(v_q[s]))] = 1'b1;
            end else if (state_q[s] == S_BLAST) begin
                blast_map = blast_map | footprint(h_q[s], v_q[s], wallMap);
            end
        end
    end

    // Decide whether a place request is accepted and which free slot takes it.
    always_comb begin
        cur_in_range = (curh <= HMAX4) && (curv <= VMAX4);
        cur_idx      = cur_in_range ? tile_idx(int'(curh), int'(curv)) : '0;
        free_found   = 1'b0;
        free_idx     = '0;
        for (int s = NUMSLOT - 1; s >= 0; s--) begin
            if (state_q[s] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = SLW'(s);
            end
        end
        accept = place && cur_in_range && free_found &&
                 !bomb_map[cur_idx] && !blast_map[cur_idx] && !wallMap[cur_idx];
    end

    // Per-slot next state: arm on accept, fuse or chain into blast, blast expiry to idle.
    always_comb begin
        place_ack_d = accept;
        for (int s = 0; s < NUMSLOT; s++) begin
            state_d[s] = state_q[s];
            h_d[s]     = h_q[s];
            v_d[s]     = v_q[s];
            timer_d[s] = timer_q[s];
            case (state_q[s])
                S_IDLE: begin
                    if (accept && free_idx == SLW'(s)) begin
                        state_d[s] = S_ARMED;
                        h_d[s]     = curh;
                        v_d[s]     = curv;
                        timer_d[s] = '0;
                    end
                end
                S_ARMED: begin
                    if (timer_q[s] == FUSE_LAST ||
                        blast_map[tile_idx(int'(h_q[s]), int'(v_q[s]))]) begin
                        state_d[s] = S_BLAST;
                        timer_d[s] = '0;
                    end else begin
                        timer_d[s] = timer_q[s] + CNTW'(1);
                    end
                end
                S_BLAST: begin
                    if (timer_q[s] == BLAST_LAST) begin
                        state_d[s] = S_IDLE;
                        timer_d[s] = '0;
                    end else begin
                        timer_d[s] = timer_q[s] + CNTW'(1);
                    end
                end
                default: begin
                    state_d[s] = S_IDLE;
                    timer_d[s] = '0;
                end
            endcase
        end
    end

    // Count the slots currently in use.
    always_comb begin
        active_cnt = '0;
        for (int s = 0; s < NUMSLOT; s++) begin
            if (state_q[s] != S_IDLE) begin
                active_cnt = active_cnt + 4'd1;
            end
        end
    end

    // Slot registers and the accept pulse; reset clears every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUMSLOT; s++) begin
                state_q[s] <= S_IDLE;
                h_q[s]     <= '0;
                v_q[s]     <= '0;
                timer_q[s] <= '0;
            end
            place_ack_q <= 1'b0;
        end else begin
            for (int s = 0; s < NUMSLOT; s++) begin
                state_q[s] <= state_d[s];
                h_q[s]     <= h_d[s];
                v_q[s]     <= v_d[s];
                timer_q[s] <= timer_d[s];
            end
            place_ack_q <= place_ack_d;
        end
    end

    assign walkAble  = {1'b1, ~wallMap & ~bomb_map};
    assign bombMap   = bomb_map;
    assign blastMap  = blast_map;
    assign placeAck  = place_ack_q;
    assign activeCnt = active_cnt;

endmodule

// File: tb/tb_bomb_manager.sv
// Bench for bomb_manager: directed scenarios followed by random traffic, every
// cycle compared against a timestamp-based model of the bomb pool.
module tb_bomb_manager;

    localparam int HM    = 9;
    localparam int VM    = 5;
    localparam int NS    = 4;
    localparam int FUSE  = 8;
    localparam int BLAST = 4;
    localparam int RNG   = 1;
    localparam int NT    = (HM + 1) * (VM + 1);

    localparam int FREE      = 0;
    localparam int FUSING    = 1;
    localparam int EXPLODING = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          place = 1'b0;
    logic [3:0]    curh = '0;
    logic [3:0]    curv = '0;
    logic [NT-1:0] wallMap = '0;
    logic [NT:0]   walkAble;
    logic [NT-1:0] bombMap;
    logic [NT-1:0] blastMap;
    logic          placeAck;
    logic [3:0]    activeCnt;

    bomb_manager #(
        .HMAXTILE (HM),
        .VMAXTILE (VM),
        .NUMSLOT  (NS),
        .FUSE_CYC (FUSE),
        .BLAST_CYC(BLAST),
        .RANGE    (RNG),
        .CNTW     (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .place    (place),
        .curh     (curh),
        .curv     (curv),
        .wallMap  (wallMap),
        .walkAble (walkAble),
        .bombMap  (bombMap),
        .blastMap (blastMap),
        .placeAck (placeAck),
        .activeCnt(activeCnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: each slot remembers what it is doing and the edge at which it started.
    int   m_kind [NS];
    int   m_t0   [NS];
    int   m_h    [NS];
    int   m_v    [NS];
    int   edge_n = 0;
    logic m_ack  = 1'b0;

    function automatic logic [5:0] ti(input int h, input int v);
        return 6'(v * (HM + 1) + h);
    endfunction

    function automatic logic [NT-1:0] m_bombs();
        logic [NT-1:0] m;
        m = '0;
        for (int s = 0; s < NS; s++) begin
            if (m_kind[s] == FUSING) m[ti(m_h[s], m_v[s])] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NT-1:0] m_blasts(input logic [NT-1:0] walls);
        logic [NT-1:0] m;
        int h;
        int v;
        m = '0;
        for (int s = 0; s < NS; s++) begin
            if (m_kind[s] == EXPLODING) begin
                h = m_h[s];
                v = m_v[s];
                m[ti(h, v)] = 1'b1;
                for (int k = 1; k <= RNG; k++) begin
                    if (h - k < 0) break;
                    if (walls[ti(h - k, v)]) break;
                    m[ti(h - k, v)] = 1'b1;
                end
                for (int k = 1; k <= RNG; k++) begin
                    if (h + k > HM) break;
                    if (walls[ti(h + k, v)]) break;
                    m[ti(h + k, v)] = 1'b1;
                end
                for (int k = 1; k <= RNG; k++) begin
                    if (v - k < 0) break;
                    if (walls[ti(h, v - k)]) break;
                    m[ti(h, v - k)] = 1'b1;
                end
                for (int k = 1; k <= RNG; k++) begin
                    if (v + k > VM) break;
                    if (walls[ti(h, v + k)]) break;
                    m[ti(h, v + k)] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model after an edge.
    task automatic checkOutput(input string tag);
        logic [NT-1:0] eb;
        logic [NT-1:0] ex;
        int cnt;
        eb  = m_bombs();
        ex  = m_blasts(wallMap);
        cnt = 0;
        for (int s = 0; s < NS; s++) if (m_kind[s] != FREE) cnt++;
        cmp({tag, ".placeAck"},  64'(placeAck),  64'(m_ack));
        cmp({tag, ".bombMap"},   64'(bombMap),   64'(eb));
        cmp({tag, ".blastMap"},  64'(blastMap),  64'(ex));
        cmp({tag, ".walkAble"},  64'(walkAble),  64'({1'b1, ~wallMap & ~eb}));
        cmp({tag, ".activeCnt"}, 64'(activeCnt), 64'(cnt));
    endtask

    // Drive one cycle of inputs, advance the model over the same edge, then check.
    task automatic applyStimulus(input logic r, input logic p, input int h, input int v);
        logic [NT-1:0] bm;
        logic [NT-1:0] xm;
        int   free;
        logic acc;
        @(negedge clk);
        rst   = r;
        place = p;
        curh  = 4'(h);
        curv  = 4'(v);
        bm = m_bombs();
        xm = m_blasts(wallMap);
        if (r) begin
            for (int s = 0; s < NS; s++) m_kind[s] = FREE;
            m_ack = 1'b0;
        end else begin
            free = -1;
            for (int s = NS - 1; s >= 0; s--) if (m_kind[s] == FREE) free = s;
            acc = 1'b0;
            if (p && h <= HM && v <= VM && free >= 0)
                acc = !bm[ti(h, v)] && !xm[ti(h, v)] && !wallMap[ti(h, v)];
            for (int s = 0; s < NS; s++) begin
                if (m_kind[s] == FUSING &&
                    (edge_n - m_t0[s] == FUSE || xm[ti(m_h[s], m_v[s])])) begin
                    m_kind[s] = EXPLODING;
                    m_t0[s]   = edge_n;
                end else if (m_kind[s] == EXPLODING && edge_n - m_t0[s] == BLAST) begin
                    m_kind[s] = FREE;
                end
            end
            if (acc) begin
                m_kind[free] = FUSING;
                m_t0[free]   = edge_n;
                m_h[free]    = h;
                m_v[free]    = v;
            end
            m_ack = acc;
        end
        edge_n++;
        @(posedge clk);
        #1;
        checkOutput(r ? "reset" : (p ? "place" : "idle"));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        logic [NT-1:0] exp_map;

        applyStimulus(1'b1, 1'b0, 0, 0);
        cmp("reset.activeCnt", 64'(activeCnt), 64'(0));
        cmp("reset.walkAble", 64'(walkAble), {3'b000, {61{1'b1}}});
        applyStimulus(1'b1, 1'b0, 0, 0);

        $display("[TB] single bomb at (3,2)");
        applyStimulus(1'b0, 1'b1, 3, 2);
        cmp("t1.ack", 64'(placeAck), 64'(1));
        cmp("t1.bomb23", 64'(bombMap[23]), 64'(1));
        cmp("t1.walk23", 64'(walkAble[23]), 64'(0));
        idle(8);
        exp_map = '0;
        exp_map[22] = 1'b1; exp_map[23] = 1'b1; exp_map[24] = 1'b1;
        exp_map[13] = 1'b1; exp_map[33] = 1'b1;
        cmp("t1.blast", 64'(blastMap), 64'(exp_map));
        cmp("t1.bombClear", 64'(bombMap), 64'(0));
        idle(4);
        cmp("t1.blastClear", 64'(blastMap), 64'(0));
        cmp("t1.cnt", 64'(activeCnt), 64'(0));

        $display("[TB] corner bomb at (0,0)");
        applyStimulus(1'b0, 1'b1, 0, 0);
        idle(8);
        exp_map = '0;
        exp_map[0] = 1'b1; exp_map[1] = 1'b1; exp_map[10] = 1'b1;
        cmp("t2.blast", 64'(blastMap), 64'(exp_map));
        idle(4);

        $display("[TB] wall stops blast arm");
        wallMap[24] = 1'b1;
        applyStimulus(1'b0, 1'b1, 3, 2);
        idle(8);
        cmp("t3.blast24", 64'(blastMap[24]), 64'(0));
        cmp("t3.blast22", 64'(blastMap[22]), 64'(1));
        applyStimulus(1'b0, 1'b1, 4, 2);
        cmp("t3.wallAck", 64'(placeAck), 64'(0));
        idle(4);
        wallMap = '0;

        $display("[TB] chain reaction");
        applyStimulus(1'b0, 1'b1, 3, 2);
        idle(1);
        applyStimulus(1'b0, 1'b1, 4, 2);
        idle(6);
        cmp("t4.secondArmed", 64'(bombMap[24]), 64'(1));
        idle(1);
        cmp("t4.chained", 64'(bombMap), 64'(0));
        cmp("t4.blast25", 64'(blastMap[25]), 64'(1));
        idle(6);

        $display("[TB] slot exhaustion and duplicates");
        applyStimulus(1'b0, 1'b1, 0, 5);
        applyStimulus(1'b0, 1'b1, 9, 5);
        applyStimulus(1'b0, 1'b1, 5, 0);
        applyStimulus(1'b0, 1'b1, 2, 2);
        applyStimulus(1'b0, 1'b1, 7, 3);
        cmp("t5.fullAck", 64'(placeAck), 64'(0));
        cmp("t5.fullCnt", 64'(activeCnt), 64'(4));
        applyStimulus(1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 2, 2);
        applyStimulus(1'b0, 1'b1, 2, 2);
        cmp("t5.dupAck", 64'(placeAck), 64'(0));
        cmp("t5.dupCnt", 64'(activeCnt), 64'(1));
        applyStimulus(1'b1, 1'b0, 0, 0);

        $display("[TB] reset mid-fuse and mid-blast");
        applyStimulus(1'b0, 1'b1, 0, 0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 9, 5);
        applyStimulus(1'b0, 1'b1, 9, 0);
        idle(5);
        cmp("t6.before", 64'(activeCnt), 64'(3));
        wallMap = '0;
        wallMap[45] = 1'b1; wallMap[7] = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0);
        cmp("t6.bomb", 64'(bombMap), 64'(0));
        cmp("t6.blast", 64'(blastMap), 64'(0));
        cmp("t6.cnt", 64'(activeCnt), 64'(0));
        cmp("t6.walk", 64'(walkAble), 64'({1'b1, ~wallMap}));
        wallMap = '0;

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            if (i % 150 == 0) begin
                for (int b = 0; b < NT; b++) wallMap[b] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 11)), int'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
